little_cpu_ctrl: RTL and testbench
==================================

# little_cpu_ctrl

Fetch/decode/execute sequencer for the little CPU. It consumes the instruction register contents and accumulator flags, and drives every load enable and mux select on the datapath: program counter, memory address register, memory, memory data register, ALU/immediate mux, ALU and accumulator. It is a Moore-style FSM with a retired-instruction counter and sits directly upstream of the datapath control inputs.

## Interface
- IR_W, 16, instruction width; opcode is `i_ir[IR_W-1 -: 4]`, operand is the remaining low bits.
- ALU_OP_W, 3, width of `o_alu_op`.
- CNT_W, 16, width of `o_retired`.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_run  in  1  level; allows fetching a new instruction.
- i_ir  in  IR_W  instruction register output.
- i_acc_zero  in  1  accumulator == 0.
- i_acc_neg  in  1  accumulator MSB.
- o_pc_ld  out  1  PC load enable.
- o_pc_sel  out  1  PC source: 0 = PC+1, 1 = IR operand.
- o_mar_ld  out  1  MAR load enable.
- o_mar_sel  out  1  MAR source: 0 = PC, 1 = IR operand.
- o_mdr_ld  out  1  MDR captures memory read data.
- o_mem_we  out  1  memory write (data = accumulator, address = MAR).
- o_ir_ld  out  1  IR captures MDR.
- o_alu_sel  out  1  ALU B operand: 0 = MDR, 1 = IR operand (zero-extended).
- o_alu_op  out  ALU_OP_W  0 = PASS_B, 1 = ADD, 2 = SUB, 3 = AND.
- o_acc_ld  out  1  accumulator load enable.
- o_instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- o_illegal  out  1  one-cycle pulse in DEC for an undefined opcode.
- o_halted  out  1  high in HALT.
- o_state  out  4  current state encoding.
- o_retired  out  CNT_W  count of completed instructions.

## Operation
- States and encodings: IDLE=0, F0=1, F1=2, F2=3, DEC=4, E0=5, E1=6, E2=7, HALT=8.
- IDLE: all controls are 0. Go to F0 if `i_run` is high.
- F0: `mar_ld=1`, `mar_sel=0`. Go to F1.
- F1: `mdr_ld=1`. Memory read is synchronous, so MDR holds mem[PC] after this edge. Go to F2.
- F2: `ir_ld=1`, `pc_ld=1`, `pc_sel=0`. Go to DEC.
- DEC decodes the opcode:
  - 0x0 NOP: done, go to F0.
  - 0x1 LDA, 0x2 STA, 0x3 ADD, 0x4 SUB, 0x5 AND: go to E0.
  - 0x6 LDI, 0x7 ADDI: go to E2.
  - 0x8 JMP: `pc_ld=1`, `pc_sel=1`; done, go to F0.
  - 0x9 JZ, 0xA JN: branch as JMP when `i_acc_zero` / `i_acc_neg` is high, otherwise NOP.
  - 0xF HLT: done, go to HALT.
  - Any other opcode: `o_illegal=1`, done, go to F0.
- E0: `mar_ld=1`, `mar_sel=1`. Go to E1.
- E1: for STA, `mem_we=1`, done, go to F0. Otherwise `mdr_ld=1`, go to E2.
- E2: `acc_ld=1`, done, go to F0.
  - LDA: PASS_B, `alu_sel=0`.
  - ADD/SUB/AND: op 1/2/3, `alu_sel=0`.
  - LDI: PASS_B, `alu_sel=1`.
  - ADDI: ADD, `alu_sel=1`.
- "Done" means `o_instr_done=1` that cycle and `o_retired` increments at the edge. The counter wraps from all-ones to 0.
- From F0, if `i_run` is low, go to IDLE with no controls asserted. The pause takes effect only at an instruction boundary; an instruction in flight always completes.
- HALT: `o_halted=1`, all controls are 0. Only reset leaves HALT.
- Undefined `o_alu_op` values are never driven. When unused, `o_alu_op` is 0.

## Timing
- Controls are combinational from the state register and `i_ir`. `i_acc_*` are used only in DEC.
- Reset: state is IDLE and `o_retired` is 0 after the reset edge. While in IDLE, all control, pulse and `o_halted` outputs are 0.
- Reset asserted in any state, including mid-instruction or HALT, returns to IDLE at that edge. Any partial instruction is abandoned; in-flight register loads in that cycle still occur.
- Cycles per instruction, counted from F0:
  - NOP, JMP/JZ/JN, HLT, illegal: 4.
  - LDI, ADDI: 5.
  - STA: 6.
  - LDA, ADD, SUB, AND: 7.
- `i_run` rising while in IDLE gives F0 on the next cycle.

## Configuration
- `LITTLE_CPU_CTRL_COND_BRANCH_EN` defined: JZ and JN behave as above.
- Not defined: opcodes 0x9 and 0xA are illegal (`o_illegal` pulse, NOP behaviour), and `i_acc_zero` / `i_acc_neg` are unused.

## Test plan
- Reset, then hold `i_run=0` for 5 cycles: `o_state`=0, all controls 0, `o_retired`=0.
- `i_run=1`, IR=0x6005 (LDI 5): states F0,F1,F2,DEC,E2. In E2, `acc_ld=1`, `alu_sel=1`, `alu_op=0`, `instr_done=1`; `o_retired`=1.
- IR=0x2010 (STA): E0 has `mar_sel=1`, `mar_ld=1`. E1 has `mem_we=1` and `instr_done=1`. Back in F0 on cycle 7.
- IR=0x9020 with `i_acc_zero=1`: DEC has `pc_ld=1`, `pc_sel=1`. With `i_acc_zero=0`: `pc_ld=0`. Without the macro: `o_illegal=1`.
- IR=0xF000: `o_halted=1` from the cycle after DEC, holds 10 cycles regardless of `i_run`. Assert `i_rst`: IDLE, `o_retired`=0.
- Assert `i_rst` during E1 of ADD: next state is IDLE and `o_retired` does not increment. Preload `o_retired`=0xFFFF then retire a NOP: `o_retired`=0x0000.

Source files
------------

// File: rtl/little_cpu_ctrl.sv
// rtl/little_cpu_ctrl.sv - fetch/decode/execute sequencer for the little CPU (option macro: LITTLE_CPU_CTRL_COND_BRANCH_EN)
module little_cpu_ctrl #(
    parameter int IR_W     = 16,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_run,
    input  logic [IR_W-1:0]     i_ir,
    input  logic                i_acc_zero,
    input  logic                i_acc_neg,
    output logic                o_pc_ld,
    output logic                o_pc_sel,
    output logic                o_mar_ld,
    output logic                o_mar_sel,
    output logic                o_mdr_ld,
    output logic                o_mem_we,
    output logic                o_ir_ld,
    output logic                o_alu_sel,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_acc_ld,
    output logic                o_instr_done,
    output logic                o_illegal,
    output logic                o_halted,
    output logic [3:0]          o_state,
    output logic [CNT_W-1:0]    o_retired
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_E0   = 4'd5,
        S_E1   = 4'd6,
        S_E2   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JN   = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(3);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] retired;
    logic [3:0]       opcode;
    logic             take_branch;
    logic             op_illegal;
    logic             unused_ok;

    assign opcode = i_ir[IR_W-1 -: 4];

`ifdef LITTLE_CPU_CTRL_COND_BRANCH_EN
    assign take_branch = (opcode == OP_JMP)
                       | ((opcode == OP_JZ) & i_acc_zero)
                       | ((opcode == OP_JN) & i_acc_neg);
    assign op_illegal  = opcode inside {[4'hB:4'hE]};
    assign unused_ok   = ^i_ir[IR_W-5:0];
`else
    // Without conditional branches the flags are ignored and JZ/JN decode as illegal.
    assign take_branch = (opcode == OP_JMP);
    assign op_illegal  = opcode inside {OP_JZ, OP_JN, [4'hB:4'hE]};
    assign unused_ok   = ^{i_ir[IR_W-5:0], i_acc_zero, i_acc_neg};
`endif

    // Moore decode of datapath controls and next state from the state register and IR.
    always_comb begin
        state_nxt    = state;
        o_pc_ld      = 1'b0;
        o_pc_sel     = 1'b0;
        o_mar_ld     = 1'b0;
        o_mar_sel    = 1'b0;
        o_mdr_ld     = 1'b0;
        o_mem_we     = 1'b0;
        o_ir_ld      = 1'b0;
        o_alu_sel    = 1'b0;
        o_alu_op     = ALU_PASS_B;
        o_acc_ld     = 1'b0;
        o_instr_done = 1'b0;
        o_illegal    = 1'b0;
        o_halted     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_run) state_nxt = S_F0;
            end
            S_F0: begin
                // Pausing is only allowed here, at an instruction boundary.
                if (i_run) begin
                    o_mar_ld  = 1'b1;
                    state_nxt = S_F1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_F1: begin
                o_mdr_ld  = 1'b1;
                state_nxt = S_F2;
            end
            S_F2: begin
                o_ir_ld   = 1'b1;
                o_pc_ld   = 1'b1;
                state_nxt = S_DEC;
            end
            S_DEC: begin
                if (opcode inside {[OP_LDA:OP_AND]}) begin
                    state_nxt = S_E0;
                end else if (opcode inside {OP_LDI, OP_ADDI}) begin
                    state_nxt = S_E2;
                end else if (opcode == OP_HLT) begin
                    o_instr_done = 1'b1;
                    state_nxt    = S_HALT;
                end else begin
                    o_pc_ld      = take_branch;
                    o_pc_sel     = take_branch;
                    o_illegal    = op_illegal;
                    o_instr_done = 1'b1;
                    state_nxt    = S_F0;
                end
            end
            S_E0: begin
                o_mar_ld  = 1'b1;
                o_mar_sel = 1'b1;
                state_nxt = S_E1;
            end
            S_E1: begin
                if (opcode == OP_STA) begin
                    o_mem_we     = 1'b1;
                    o_instr_done = 1'b1;
                    state_nxt    = S_F0;
                end else begin
                    o_mdr_ld  = 1'b1;
                    state_nxt = S_E2;
                end
            end
            S_E2: begin
                o_acc_ld     = 1'b1;
                o_instr_done = 1'b1;
                state_nxt    = S_F0;
                case (opcode)
                    OP_ADD:  o_alu_op = ALU_ADD;
                    OP_SUB:  o_alu_op = ALU_SUB;
                    OP_AND:  o_alu_op = ALU_AND;
                    OP_LDI:  o_alu_sel = 1'b1;
                    OP_ADDI: begin
                        o_alu_sel = 1'b1;
                        o_alu_op  = ALU_ADD;
                    end
                    default: o_alu_op = ALU_PASS_B;
                endcase
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and retired-instruction counter; reset abandons any partial instruction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (o_instr_done) retired <= retired + CNT_W'(1);
        end
    end

    assign o_state   = state;
    assign o_retired = retired;
endmodule

// File: tb/tb_little_cpu_ctrl.sv
// tb/tb_little_cpu_ctrl.sv - self-checking bench for little_cpu_ctrl
module tb_little_cpu_ctrl;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [15:0]   ir;
    logic          zero;
    logic          neg;
    logic          pc_ld, pc_sel, mar_ld, mar_sel, mdr_ld, mem_we, ir_ld, alu_sel;
    logic [2:0]    alu_op;
    logic          acc_ld, instr_done, illegal, halted;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] exp_ret;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_ld;
        logic       pc_sel;
        logic       mar_ld;
        logic       mar_sel;
        logic       mdr_ld;
        logic       mem_we;
        logic       ir_ld;
        logic       alu_sel;
        logic [2:0] alu_op;
        logic       acc_ld;
        logic       done;
        logic       illegal;
        logic       halted;
    } exp_t;

    exp_t sq[$];

    little_cpu_ctrl #(.IR_W(16), .ALU_OP_W(3), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (run),
        .i_ir         (ir),
        .i_acc_zero   (zero),
        .i_acc_neg    (neg),
        .o_pc_ld      (pc_ld),
        .o_pc_sel     (pc_sel),
        .o_mar_ld     (mar_ld),
        .o_mar_sel    (mar_sel),
        .o_mdr_ld     (mdr_ld),
        .o_mem_we     (mem_we),
        .o_ir_ld      (ir_ld),
        .o_alu_sel    (alu_sel),
        .o_alu_op     (alu_op),
        .o_acc_ld     (acc_ld),
        .o_instr_done (instr_done),
        .o_illegal    (illegal),
        .o_halted     (halted),
        .o_state      (state),
        .o_retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t e;
        e.st = state;      e.pc_ld = pc_ld;     e.pc_sel = pc_sel;
        e.mar_ld = mar_ld; e.mar_sel = mar_sel; e.mdr_ld = mdr_ld;
        e.mem_we = mem_we; e.ir_ld = ir_ld;     e.alu_sel = alu_sel;
        e.alu_op = alu_op; e.acc_ld = acc_ld;   e.done = instr_done;
        e.illegal = illegal; e.halted = halted;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input exp_t e);
        #1;
        chk(tag, 32'(obs()), 32'(e));
        chk({tag, "_retired"}, 32'(retired), 32'(exp_ret));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle schedule of one instruction, from F0 to its last cycle.
    task automatic build(input logic [15:0] instr, input logic z, input logic n);
        exp_t e;
        exp_t d;
        logic [3:0] op;
        logic cond_en;
`ifdef LITTLE_CPU_CTRL_COND_BRANCH_EN
        cond_en = 1'b1;
`else
        cond_en = 1'b0;
`endif
        op = instr[15:12];
        sq = {};
        e = mk(4'd1); e.mar_ld = 1'b1; sq.push_back(e);
        e = mk(4'd2); e.mdr_ld = 1'b1; sq.push_back(e);
        e = mk(4'd3); e.ir_ld = 1'b1; e.pc_ld = 1'b1; sq.push_back(e);
        d = mk(4'd4);
        if (op >= 4'h1 && op <= 4'h5) begin
            sq.push_back(d);
            e = mk(4'd5); e.mar_ld = 1'b1; e.mar_sel = 1'b1; sq.push_back(e);
            e = mk(4'd6);
            if (op == 4'h2) begin
                e.mem_we = 1'b1; e.done = 1'b1; sq.push_back(e);
            end else begin
                e.mdr_ld = 1'b1; sq.push_back(e);
                e = mk(4'd7); e.acc_ld = 1'b1; e.done = 1'b1;
                e.alu_op = (op == 4'h1) ? 3'd0 : 3'(op - 4'h2);
                sq.push_back(e);
            end
        end else if (op == 4'h6 || op == 4'h7) begin
            sq.push_back(d);
            e = mk(4'd7); e.acc_ld = 1'b1; e.done = 1'b1; e.alu_sel = 1'b1;
            e.alu_op = (op == 4'h7) ? 3'd1 : 3'd0;
            sq.push_back(e);
        end else begin
            d.done = 1'b1;
            if (op == 4'h8 || (cond_en && ((op == 4'h9 && z) || (op == 4'hA && n)))) begin
                d.pc_ld = 1'b1; d.pc_sel = 1'b1;
            end
            if ((op >= 4'hB && op <= 4'hE) || (!cond_en && (op == 4'h9 || op == 4'hA)))
                d.illegal = 1'b1;
            sq.push_back(d);
        end
    endtask

    // Runs one instruction from its F0 cycle; abort_at selects a cycle in which reset is asserted.
    task automatic run_instr(input string tag, input logic [15:0] instr, input logic z,
                             input logic n, input int abort_at);
        ir = instr; zero = z; neg = n;
        build(instr, z, n);
        for (int idx = 0; idx < sq.size(); idx++) begin
            if (idx > 0) run = 1'($urandom_range(0, 1));
            if (idx == abort_at) rst = 1'b1;
            chk_cycle($sformatf("%s_c%0d", tag, idx), sq[idx]);
            if (idx == abort_at) begin
                tick();
                rst = 1'b0;
                exp_ret = '0;
                chk_cycle({tag, "_after_rst"}, mk(4'd0));
                return;
            end
            if (sq[idx].done) exp_ret = exp_ret + 1'b1;
            tick();
        end
    endtask

    task automatic idle_to_f0(input string tag);
        run = 1'b1;
        chk_cycle({tag, "_idle"}, mk(4'd0));
        tick();
    endtask

    task automatic pause_at_f0(input string tag, input int cycles);
        run = 1'b0;
        chk_cycle({tag, "_f0_pause"}, mk(4'd1));
        tick();
        for (int k = 0; k < cycles; k++) begin
            chk_cycle({tag, "_idle_hold"}, mk(4'd0));
            tick();
        end
        idle_to_f0(tag);
    endtask

    initial begin
        exp_t h;
        logic [3:0] op;
        rst = 1'b1; run = 1'b0; ir = '0; zero = 1'b0; neg = 1'b0;
        exp_ret = '0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_cycle("reset_idle", mk(4'd0));
            tick();
        end
        idle_to_f0("start");

        run_instr("ldi5", 16'h6005, 1'b0, 1'b0, -1);
        chk("ldi_retired_one", 32'(retired), 32'd1);
        run = 1'b1;

        run_instr("sta", 16'h2010, 1'b0, 1'b0, -1);
        run = 1'b1;
        chk("sta_back_in_f0", 32'(state), 32'd1);

        run_instr("jz_taken", 16'h9020, 1'b1, 1'b0, -1);
        run = 1'b1;
        run_instr("jz_not_taken", 16'h9020, 1'b0, 1'b1, -1);
        run = 1'b1;
        run_instr("jn_taken", 16'hA020, 1'b0, 1'b1, -1);
        run = 1'b1;

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) pause_at_f0("rnd", $urandom_range(0, 3));
            run = 1'b1;
            run_instr($sformatf("rnd%0d_op%h", i, op), {op, 12'($urandom)},
                      1'($urandom), 1'($urandom), -1);
        end
        run = 1'b1;

        run_instr("add_rst_e1", 16'h3044, 1'b0, 1'b0, 5);
        idle_to_f0("post_abort");

        while (exp_ret != {CW{1'b1}}) begin
            run = 1'b1;
            run_instr("nop_fill", 16'h0000, 1'b0, 1'b0, -1);
        end
        run = 1'b1;
        run_instr("nop_wrap", 16'h0123, 1'b0, 1'b0, -1);
        chk("retired_wrap", 32'(retired), 32'd0);
        run = 1'b1;

        run_instr("hlt", 16'hF000, 1'b0, 1'b0, -1);
        h = mk(4'd8);
        h.halted = 1'b1;
        for (int k = 0; k < 10; k++) begin
            run = 1'($urandom_range(0, 1));
            chk_cycle("halt_hold", h);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ret = '0;
        chk_cycle("halt_reset", mk(4'd0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
